// File: rtl/fp_addsub_arbiter.sv
// ============================================================================
// Module      : fp_addsub_arbiter (plus combinational core add_sub)
// Description : Round-robin arbiter that shares one single-precision FP
//               add/sub core among NUM_REQ requesters. Operands and results
//               are registered around the core, and every port uses a
//               valid/ready handshake.
//               Optional macro FP_ARB_STATS_EN adds saturating
//               overflow/underflow counters with a synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Combinational IEEE-754 single-precision adder/subtractor.
// Round to nearest even. Subnormal inputs are treated as zero, and results
// below the normal range are flushed to signed zero with underflow set.
module add_sub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,          // 1 = a + b, 0 = a - b
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);
    logic        w_sa, w_sb, w_sx, w_sy, w_up;
    logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_diff;
    logic [23:0] w_ma, w_mb, w_mx, w_my;
    logic [4:0]  w_sh, w_lz;
    logic [26:0] w_y_ext, w_y_lost, w_y_al, w_n;
    logic [27:0] w_sum;
    logic [30:0] w_packed;
    logic signed [9:0] w_e;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;

    // Align, add, normalise, round and classify in one combinational pass
    always_comb begin
        w_sa    = a[31];
        w_sb    = b[31] ^ ~op;       // subtraction flips the sign of b
        w_ea    = a[30:23];
        w_eb    = b[30:23];
        w_a_nan = (w_ea == 8'hFF) && (a[22:0] != 23'd0);
        w_b_nan = (w_eb == 8'hFF) && (b[22:0] != 23'd0);
        w_a_inf = (w_ea == 8'hFF) && (a[22:0] == 23'd0);
        w_b_inf = (w_eb == 8'hFF) && (b[22:0] == 23'd0);
        w_ma    = (w_ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        w_mb    = (w_eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
        // x always holds the larger magnitude so the difference is non-negative
        if ({w_eb, w_mb} > {w_ea, w_ma}) begin
            w_sx = w_sb; w_ex = w_eb; w_mx = w_mb;
            w_sy = w_sa; w_ey = w_ea; w_my = w_ma;
        end else begin
            w_sx = w_sa; w_ex = w_ea; w_mx = w_ma;
            w_sy = w_sb; w_ey = w_eb; w_my = w_mb;
        end
        w_diff   = w_ex - w_ey;
        w_sh     = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
        w_y_ext  = {w_my, 3'b000};
        w_y_lost = w_y_ext & ((27'd1 << w_sh) - 27'd1);
        w_y_al   = (w_y_ext >> w_sh) | {26'd0, |w_y_lost};
        if (w_sx == w_sy)
            w_sum = {1'b0, w_mx, 3'b000} + {1'b0, w_y_al};
        else
            w_sum = {1'b0, w_mx, 3'b000} - {1'b0, w_y_al};
        w_lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (w_sum[i]) w_lz = 5'(26 - i);
        if (w_sum[27]) begin
            w_n = {w_sum[27:2], |w_sum[1:0]};
            w_e = $signed({2'b00, w_ex}) + 10'sd1;
        end else begin
            w_n = w_sum[26:0] << w_lz;
            w_e = $signed({2'b00, w_ex}) - $signed({5'd0, w_lz});
        end
        w_up = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
        // Hidden bit lands on exponent-1, so a rounding carry bumps the exponent
        w_packed = {w_e[7:0] - 8'd1, 23'd0} + {7'd0, w_n[26:3]} + {30'd0, w_up};

        result    = 32'd0;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
            result = 32'h7FC0_0000;
        else if (w_a_inf)
            result = {w_sa, 8'hFF, 23'd0};
        else if (w_b_inf)
            result = {w_sb, 8'hFF, 23'd0};
        else if (w_mx == 24'd0)
            result = {w_sa & w_sb, 31'd0};
        else if (w_sum == 28'd0)
            result = 32'd0;
        else if (w_e <= 0) begin
            result    = {w_sx, 31'd0};
            underflow = 1'b1;
        end else if ((w_e >= 255) || (w_packed[30:23] == 8'hFF)) begin
            result   = {w_sx, 8'hFF, 23'd0};
            overflow = 1'b1;
        end else
            result = {w_sx, w_packed};
    end
endmodule

module fp_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
`ifdef FP_ARB_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_result,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_overflow,
    output logic                  out_underflow,
`ifdef FP_ARB_STATS_EN
    output logic [CNT_W-1:0]      ovf_count,
    output logic [CNT_W-1:0]      unf_count,
    input  logic                  stats_clr,
`endif
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t          r_state, w_next;
    logic [ID_W-1:0] r_rr_ptr, w_winner, r_op_id;
    logic [31:0]     r_op_a, r_op_b, w_sel_a, w_sel_b, w_core_result;
    logic            r_op_op, w_sel_op, w_any, w_grant_ok, w_grant;
    logic            w_core_ovf, w_core_unf;
    int              w_idx;

    add_sub u_core (
        .a         (r_op_a),
        .b         (r_op_b),
        .op        (r_op_op),
        .result    (w_core_result),
        .overflow  (w_core_ovf),
        .underflow (w_core_unf)
    );

    // Round-robin search from rr_ptr upward, then select the winner's operands
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        w_sel_a  = 32'd0;
        w_sel_b  = 32'd0;
        w_sel_op = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = ID_W'(w_idx);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == ID_W'(k)) begin
                w_sel_a  = req_a[32*k +: 32];
                w_sel_b  = req_b[32*k +: 32];
                w_sel_op = req_op[k];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and grant; a grant is only possible when the output slot frees
    always_comb begin
        w_next     = r_state;
        w_grant_ok = 1'b0;
        case (r_state)
            IDLE:    w_grant_ok = 1'b1;
            EXEC:    w_next     = DONE;
            DONE:    w_grant_ok = out_ready;
            default: w_next     = IDLE;
        endcase
        w_grant = w_grant_ok & w_any;
        if (w_grant_ok)
            w_next = w_grant ? EXEC : IDLE;
        req_ready = '0;
        if (w_grant)
            req_ready[w_winner] = 1'b1;
    end

    assign busy = (r_state != IDLE);

    // Operand capture on grant, result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_op_a        <= 32'd0;
            r_op_b        <= 32'd0;
            r_op_op       <= 1'b0;
            r_op_id       <= '0;
            out_valid     <= 1'b0;
            out_result    <= 32'd0;
            out_id        <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            if (w_grant) begin
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
                r_op_op  <= w_sel_op;
                r_op_id  <= w_winner;
                r_rr_ptr <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
            end
            if (r_state == EXEC) begin
                out_valid     <= 1'b1;
                out_result    <= w_core_result;
                out_id        <= r_op_id;
                out_overflow  <= w_core_ovf;
                out_underflow <= w_core_unf;
            end else if ((r_state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FP_ARB_STATS_EN
    // Saturating flag counters over accepted results; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else if (stats_clr) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else if (out_valid && out_ready) begin
            if (out_overflow && (ovf_count != '1))  ovf_count <= ovf_count + 1'b1;
            if (out_underflow && (unf_count != '1)) unf_count <= unf_count + 1'b1;
        end
    end
`endif
endmodule

`default_nettype wire

// File: tb/tb_fp_addsub_arbiter.sv
// ============================================================================
// Module      : tb_fp_addsub_arbiter
// Description : Directed, table-driven bench for fp_addsub_arbiter with
//               hand-written sequences for round-robin, back-pressure and
//               asynchronous reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_addsub_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a = '0;
    logic [32*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]    req_op = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [31:0]           out_result;
    logic [ID_W-1:0]       out_id;
    logic                  out_overflow, out_underflow, busy;
    int                    checks = 0;
    int                    passed = 0;
    int                    cyc = 0;
    vec_t                  vecs[10];

`ifdef FP_ARB_STATS_EN
    logic [1:0] ovf_count, unf_count;
    logic       stats_clr = 1'b0;
    fp_addsub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_id(out_id),
        .out_overflow(out_overflow), .out_underflow(out_underflow),
        .ovf_count(ovf_count), .unf_count(unf_count), .stats_clr(stats_clr),
        .busy(busy));
`else
    fp_addsub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_id(out_id),
        .out_overflow(out_overflow), .out_underflow(out_underflow),
        .busy(busy));
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic drive_req(input int idx, input logic [31:0] a, input logic [31:0] b, input logic op);
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_op[idx]         = op;
        req_valid[idx]      = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid();
        for (int t = 0; t < 10; t++) begin
            if (out_valid) return;
            @(negedge clk);
        end
        checks++;
        $display("FAIL out_valid timeout: got 0 required 1");
    endtask

    // Single transaction through an idle arbiter with full timing checks
    task automatic run_vec(input vec_t v, input int n);
        @(negedge clk);
        drive_req(v.idx, v.a, v.b, v.op);
        #1 chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(1 << v.idx));
        @(negedge clk);
        req_valid = '0;
        chk($sformatf("v%0d exec busy", n), 32'(busy), 32'd1);
        chk($sformatf("v%0d exec out_valid", n), 32'(out_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d out_valid", n), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d out_result", n), out_result, v.res);
        chk($sformatf("v%0d out_id", n), 32'(out_id), 32'(v.idx));
        chk($sformatf("v%0d out_overflow", n), 32'(out_overflow), 32'(v.ovf));
        chk($sformatf("v%0d out_underflow", n), 32'(out_underflow), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d drained out_valid", n), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d drained busy", n), 32'(busy), 32'd0);
    endtask

    initial begin : main
        logic [31:0] rr_a[4];
        logic [31:0] rr_res[4];
        int          last;

        vecs[0] = '{0, 32'h40A0_0000, 32'h40E0_0000, 1'b1, 32'h4140_0000, 1'b0}; // 5+7=12
        vecs[1] = '{1, 32'h7F80_0000, 32'h4060_0000, 1'b1, 32'h7F80_0000, 1'b0}; // Inf+3.5
        vecs[2] = '{2, 32'h40A0_0000, 32'h40E0_0000, 1'b0, 32'hC000_0000, 1'b0}; // 5-7=-2
        vecs[3] = '{3, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h0000_0000, 1'b0}; // 1-1=+0
        vecs[4] = '{0, 32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0}; // tie to even
        vecs[5] = '{1, 32'h3F80_0001, 32'h3380_0000, 1'b1, 32'h3F80_0002, 1'b0}; // tie, odd rounds up
        vecs[6] = '{2, 32'h3F80_0000, 32'h3380_0000, 1'b1, 32'h3F80_0000, 1'b0}; // tie, even stays
        vecs[7] = '{3, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h7F80_0000, 1'b1}; // max+max overflows
        vecs[8] = '{0, 32'h7FC0_0000, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 1'b0}; // NaN propagates
        vecs[9] = '{1, 32'hC040_0000, 32'h4040_0000, 1'b1, 32'h0000_0000, 1'b0}; // -3+3=+0
        rr_a   = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        rr_res = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};

        #2;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_result", out_result, 32'd0);
        chk("reset out_id", 32'(out_id), 32'd0);
        chk("reset flags", 32'({out_overflow, out_underflow}), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Round-robin with every requester valid and the consumer always ready
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) drive_req(i, rr_a[i], 32'h3F80_0000, 1'b1);
        out_ready = 1'b1;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_valid();
            chk($sformatf("rr%0d out_id", k), 32'(out_id), 32'(k % 4));
            chk($sformatf("rr%0d out_result", k), out_result, rr_res[k % 4]);
            if (k > 0) chk($sformatf("rr%0d spacing", k), 32'(cyc - last), 32'd2);
            last = cyc;
            @(negedge clk);
        end
        req_valid = '0;
        out_ready = 1'b0;

        // Back-pressure holds the result and blocks grants; release grants req 2
        do_reset();
        @(negedge clk);
        drive_req(0, 32'h40A0_0000, 32'h40E0_0000, 1'b1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        drive_req(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d out_result", c), out_result, 32'h4140_0000);
            chk($sformatf("bp%0d out_id", c), 32'(out_id), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp release req_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        out_ready = 1'b0;
        req_valid = '0;
        chk("bp exec out_valid", 32'(out_valid), 32'd0);
        chk("bp exec busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("bp second out_valid", 32'(out_valid), 32'd1);
        chk("bp second out_result", out_result, 32'h4080_0000);
        chk("bp second out_id", 32'(out_id), 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset during EXEC drops the operation and clears rr_ptr
        @(negedge clk);
        drive_req(2, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
        @(negedge clk);
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst out_result", out_result, 32'd0);
        chk("arst out_id", 32'(out_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("arst dropped%0d", c), 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        drive_req(1, 32'h4000_0000, 32'h3F80_0000, 1'b1);
        drive_req(3, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
        #1 chk("arst rr from 0", 32'(req_ready), 32'b0010);
        req_valid[1] = 1'b0;
        #1 chk("arst req3 alone", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("arst req3 out_valid", 32'(out_valid), 32'd1);
        chk("arst req3 out_id", 32'(out_id), 32'd3);
        chk("arst req3 out_result", out_result, 32'h4000_0000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

`ifdef FP_ARB_STATS_EN
        do_reset();
        for (int r = 0; r < 4; r++) run_vec(vecs[7], 20 + r);
        chk("stats ovf saturated", 32'(ovf_count), 32'd3);
        chk("stats unf", 32'(unf_count), 32'd0);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("stats cleared", 32'(ovf_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

`default_nettype wire
